// File: rtl/head_prune_mean_pkg.sv
// Shared definitions for the head-pruning mean block: FSM encoding,
// default parameter values and the accumulator width helper.
package head_prune_mean_pkg;

    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned DEF_LANES    = 4;
    localparam int unsigned DEF_MATRICES = 2;
    localparam int unsigned DEF_ELEMS    = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Sign bit plus one extra bit for |min| plus headroom for TOTAL terms.
    function automatic int unsigned acc_width(input int unsigned width,
                                              input int unsigned total);
        return width + 1 + $clog2(total);
    endfunction

endpackage

// File: rtl/head_prune_mean_lane_abs_sum.sv
// Combinational sum of LANES signed elements, optionally taking |x| first,
// sign-extended to OUT_W bits.
module lane_abs_sum #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 4,
    parameter int unsigned OUT_W = 22
) (
    input  logic [LANES*WIDTH-1:0] lanes_i,
    input  logic                   mode_abs,
    output logic signed [OUT_W-1:0] sum_c
);

    logic signed [WIDTH:0] ext [LANES];
    logic signed [WIDTH:0] mag [LANES];

    // One extra bit so that |-2^(WIDTH-1)| is representable.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign ext[g] = {lanes_i[g*WIDTH + WIDTH-1], lanes_i[g*WIDTH +: WIDTH]};
        assign mag[g] = (mode_abs && ext[g][WIDTH]) ? -ext[g] : ext[g];
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_c = sum_c + OUT_W'(mag[i]);
        end
    end

endmodule

// File: rtl/head_prune_mean.sv
// Accumulates a run of score-matrix elements, computes their floor mean and
// flags the head for pruning when the mean falls below a latched threshold.
module head_prune_mean
    import head_prune_mean_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned LANES    = DEF_LANES,
    parameter int unsigned MATRICES = DEF_MATRICES,
    parameter int unsigned ELEMS    = DEF_ELEMS
) (
    input  logic                   clk,
    input  logic                   _reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   mode_abs,
    input  logic [WIDTH-1:0]       threshold,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH:0]         mean_out,
    output logic                   prune_head
);

    localparam int unsigned TOTAL = MATRICES * ELEMS;
    localparam int unsigned BEATS = TOTAL / LANES;
    localparam int unsigned ACC_W = acc_width(WIDTH, TOTAL);
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      mode_q, mode_d;
    logic [WIDTH-1:0]          thr_q, thr_d;
    logic                      busy_q, busy_d;
    logic                      in_ready_q, in_ready_d;
    logic                      done_q, done_d;
    logic [WIDTH:0]            mean_q, mean_d;
    logic                      prune_q, prune_d;

    logic signed [ACC_W-1:0]   lane_sum_c;
    logic signed [WIDTH:0]     mean_c;
    logic signed [WIDTH:0]     thr_ext_c;
    logic                      accept_c;

    lane_abs_sum #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .OUT_W (ACC_W)
    ) u_lane_abs_sum (
        .lanes_i  (in_data),
        .mode_abs (mode_q),
        .sum_c    (lane_sum_c)
    );

    // Top WIDTH+1 bits of the accumulator == arithmetic shift by log2(TOTAL).
    assign mean_c    = acc_q[ACC_W-1 -: WIDTH+1];
    assign thr_ext_c = {thr_q[WIDTH-1], thr_q};
    assign accept_c  = in_valid && (state_q == ST_ACCUM);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        thr_d   = thr_q;
        mean_d  = mean_q;
        prune_d = prune_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    mode_d  = mode_abs;
                    thr_d   = threshold;
                end
            end
            ST_ACCUM: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept_c) begin
                    acc_d = acc_q + lane_sum_c;
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_COMPARE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_COMPARE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    mean_d  = mean_c;
                    prune_d = (mean_c < thr_ext_c);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered decodes of the next state.
        busy_d     = (state_d != ST_IDLE);
        in_ready_d = (state_d == ST_ACCUM);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge _reset) begin
        if (_reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            thr_q      <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            mean_q     <= '0;
            prune_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            thr_q      <= thr_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            mean_q     <= mean_d;
            prune_q    <= prune_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign mean_out   = mean_q;
    assign prune_head = prune_q;

endmodule

// File: doc/head_prune_mean.md
HEAD_PRUNE_MEAN -- requirements
Module: head_prune_mean

Interface
REQ-001 Parameter WIDTH, default 16: bit width of each signed input element.
REQ-002 Parameter LANES, default 4: number of elements accepted per beat.
REQ-003 Parameter MATRICES, default 2: number of score matrices per run.
REQ-004 Parameter ELEMS, default 16: number of elements per matrix.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port _reset, input, 1: asynchronous, active-high reset.
REQ-007 Port start, input, 1: begin a run; sampled only in IDLE.
REQ-008 Port abort, input, 1: cancel the current run.
REQ-009 Port mode_abs, input, 1: 1 = accumulate |x|, 0 = accumulate signed x; latched on start.
REQ-010 Port threshold, input, WIDTH: signed prune threshold; latched on start.
REQ-011 Port in_valid, input, 1: in_data beat valid.
REQ-012 Port in_ready, output, 1: module accepts a beat.
REQ-013 Port in_data, input, LANES*WIDTH: packed signed elements, lane 0 in the LSBs.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port done, output, 1: single-cycle pulse when a result is valid.
REQ-016 Port mean_out, output, WIDTH+1: signed mean of the last completed run.
REQ-017 Port prune_head, output, 1: 1 when mean_out < threshold for the last completed run.

Function
REQ-018 TOTAL = MATRICES*ELEMS shall be a power of two and divisible by LANES; BEATS = TOTAL/LANES.
REQ-019 FSM states: IDLE, ACCUM, COMPARE, DONE.
REQ-020 IDLE -> ACCUM on start; the accumulator and beat counter are cleared, and mode_abs and threshold are latched.
REQ-021 in_ready = 1 only in ACCUM; a beat is accepted when in_valid and in_ready are both high.
REQ-022 Per accepted beat, the accumulator adds the sum of LANES lane values (|x| or x per mode), each sign-extended to the accumulator width.
REQ-023 The accumulator width is WIDTH+1+clog2(TOTAL), so no overflow is possible, including |-2^(WIDTH-1)|.
REQ-024 The beat counter wraps 0..BEATS-1; acceptance of beat BEATS-1 moves ACCUM -> COMPARE.
REQ-025 In COMPARE, mean = accumulator >>> clog2(TOTAL) (arithmetic shift, floor), truncated to WIDTH+1 bits.
REQ-026 COMPARE registers mean_out and prune_head = (mean < sign-extended threshold), then moves to DONE.
REQ-027 DONE asserts done for one cycle, then moves to IDLE.
REQ-028 Latency from the last accepted beat to done is 2 cycles.
REQ-029 mean_out and prune_head hold their values until the next COMPARE.
REQ-030 start in any state other than IDLE is ignored.
REQ-031 abort in ACCUM or COMPARE returns the FSM to IDLE next cycle: no done pulse, outputs unchanged.
REQ-032 abort and start asserted together in IDLE: abort wins, and the FSM stays in IDLE.
REQ-033 abort in DONE is ignored, and the done pulse still occurs.
REQ-034 in_valid outside ACCUM is ignored, and no data is consumed.

Reset
REQ-035 _reset = 1 forces, asynchronously: state IDLE, accumulator 0, counter 0, done 0, busy 0, in_ready 0, mean_out 0, prune_head 0, latched mode 0, latched threshold 0.
REQ-036 Reset during any state discards the run in progress; operation resumes on the first clock after deassertion.

Structure
REQ-037 The shared package holds the FSM state encoding, the default parameter values, and an accumulator-width function.
REQ-038 One sub-module, lane_abs_sum, shall compute the combinational sum of LANES (optionally absolute) values.
REQ-039 The block sits downstream of the systolic add array, fed from its result outputs.

Verification
REQ-040 Defaults, mode_abs = 0, all 32 elements = 8, threshold = 10 -> done 2 cycles after beat 8, mean_out = 8, prune_head = 1.
REQ-041 mode_abs = 1, elements alternate -20/+20, threshold = 10 -> mean_out = 20, prune_head = 0; with mode_abs = 0 -> mean_out = 0, prune_head = 1.
REQ-042 in_valid toggled every other cycle over 8 beats -> exactly 8 beats consumed, one done pulse, correct mean.
REQ-043 abort after beat 3, then a new run with all elements = -32768 and mode_abs = 1 -> first run gives no done; second run gives mean_out = 32768, no overflow.
REQ-044 _reset asserted mid-ACCUM -> all outputs 0 immediately; start after reset deasserts yields a correct fresh run.
REQ-045 start pulsed during ACCUM and abort during DONE -> both ignored; a single done pulse occurs.
